// File: rtl/int_entry_if.sv
// Stack-memory bus between the interrupt entry/return sequencer and data memory.
// Writes commit on the rising edge; read data appears on mem_din the cycle after mem_r_en.
interface int_entry_if;
    logic [15:0] mem_addr;
    logic [7:0]  mem_dout;
    logic        mem_w_en;
    logic        mem_r_en;
    logic [7:0]  mem_din;

    modport master (
        output mem_addr,
        output mem_dout,
        output mem_w_en,
        output mem_r_en,
        input  mem_din
    );

    modport slave (
        input  mem_addr,
        input  mem_dout,
        input  mem_w_en,
        input  mem_r_en,
        output mem_din
    );
endinterface

// File: rtl/int_entry.sv
// Interrupt entry/return sequencer: pushes PC and flags on interrupt and jumps to the vector,
// and pops them back on reti. The CPU is stalled for the whole sequence.
module int_entry (
    input  logic        clk,
    input  logic        reset,
    input  logic        interrupt,
    input  logic [15:0] intVect,
    output logic        intAck,
    input  logic        instr_boundary,
    input  logic        ei,
    input  logic        di,
    input  logic        reti,
    input  logic [15:0] pc_in,
    input  logic [7:0]  flags_in,
    input  logic [15:0] sp_in,
    output logic [15:0] pc_out,
    output logic        pc_load,
    output logic [7:0]  flags_out,
    output logic        flags_load,
    output logic [15:0] sp_out,
    output logic        sp_load,
    int_entry_if.master mem,
    output logic        stall,
    output logic        ie,
    output logic [3:0]  dbg_state
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        PUSH_H  = 4'd1,
        PUSH_L  = 4'd2,
        PUSH_F  = 4'd3,
        JUMP    = 4'd4,
        POP_F   = 4'd5,
        POP_L   = 4'd6,
        POP_H   = 4'd7,
        RET_CAP = 4'd8,
        RESUME  = 4'd9
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] vec_q, vec_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  flags_q, flags_d;
    logic [15:0] sp_q, sp_d;
    logic        ie_q, ie_d;

    logic [15:0] mem_addr_c;
    logic [7:0]  mem_dout_c;
    logic        mem_w_en_c;
    logic        mem_r_en_c;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            vec_q   <= 16'h0000;
            pc_q    <= 16'h0000;
            flags_q <= 8'h00;
            sp_q    <= 16'h0000;
            ie_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            pc_q    <= pc_d;
            flags_q <= flags_d;
            sp_q    <= sp_d;
            ie_q    <= ie_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        pc_d       = pc_q;
        flags_d    = flags_q;
        sp_d       = sp_q;
        ie_d       = ie_q;
        intAck     = 1'b0;
        pc_out     = 16'h0000;
        pc_load    = 1'b0;
        flags_out  = 8'h00;
        flags_load = 1'b0;
        sp_out     = 16'h0000;
        sp_load    = 1'b0;
        mem_addr_c = 16'h0000;
        mem_dout_c = 8'h00;
        mem_w_en_c = 1'b0;
        mem_r_en_c = 1'b0;
        stall      = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (instr_boundary) begin
                    if (di)      ie_d = 1'b0;
                    else if (ei) ie_d = 1'b1;
                end
                // reti outranks a pending interrupt; acceptance uses the registered enable.
                if (instr_boundary && reti) begin
                    sp_d    = sp_in;
                    state_d = POP_F;
                end else if (instr_boundary && interrupt && ie_q) begin
                    vec_d   = intVect;
                    pc_d    = pc_in;
                    flags_d = flags_in;
                    sp_d    = sp_in;
                    state_d = PUSH_H;
                end
            end
            PUSH_H: begin
                intAck     = 1'b1;
                mem_w_en_c = 1'b1;
                mem_addr_c = sp_q - 16'd1;
                mem_dout_c = pc_q[15:8];
                state_d    = PUSH_L;
            end
            PUSH_L: begin
                mem_w_en_c = 1'b1;
                mem_addr_c = sp_q - 16'd2;
                mem_dout_c = pc_q[7:0];
                state_d    = PUSH_F;
            end
            PUSH_F: begin
                mem_w_en_c = 1'b1;
                mem_addr_c = sp_q - 16'd3;
                mem_dout_c = flags_q;
                state_d    = JUMP;
            end
            JUMP: begin
                pc_load = 1'b1;
                pc_out  = vec_q;
                sp_load = 1'b1;
                sp_out  = sp_q - 16'd3;
                ie_d    = 1'b0;
                state_d = IDLE;
            end
            // Read data lags the address by one cycle, so each capture sits one state later.
            POP_F: begin
                mem_r_en_c = 1'b1;
                mem_addr_c = sp_q;
                state_d    = POP_L;
            end
            POP_L: begin
                mem_r_en_c = 1'b1;
                mem_addr_c = sp_q + 16'd1;
                flags_d    = mem.mem_din;
                state_d    = POP_H;
            end
            POP_H: begin
                mem_r_en_c = 1'b1;
                mem_addr_c = sp_q + 16'd2;
                pc_d[7:0]  = mem.mem_din;
                state_d    = RET_CAP;
            end
            RET_CAP: begin
                pc_d[15:8] = mem.mem_din;
                state_d    = RESUME;
            end
            RESUME: begin
                pc_load    = 1'b1;
                pc_out     = pc_q;
                flags_load = 1'b1;
                flags_out  = flags_q;
                sp_load    = 1'b1;
                sp_out     = sp_q + 16'd3;
                ie_d       = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem.mem_addr = mem_addr_c;
    assign mem.mem_dout = mem_dout_c;
    assign mem.mem_w_en = mem_w_en_c;
    assign mem.mem_r_en = mem_r_en_c;
    assign ie           = ie_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_int_entry.sv
// Directed bench for int_entry: a sequence-level model predicts every cycle's outputs,
// and literal checks pin memory contents, loaded values and stall lengths.
module tb_int_entry;

    typedef struct packed {
        logic        stall;
        logic        int_ack;
        logic        w;
        logic        r;
        logic [15:0] addr;
        logic [7:0]  dout;
        logic        pc_load;
        logic [15:0] pc_out;
        logic        flags_load;
        logic [7:0]  flags_out;
        logic        sp_load;
        logic [15:0] sp_out;
        logic        ie;
    } obs_t;
    localparam int OBS_W = $bits(obs_t);

    logic        clk = 1'b0;
    logic        reset;
    logic        interrupt;
    logic [15:0] intVect;
    logic        intAck;
    logic        instr_boundary, ei, di, reti;
    logic [15:0] pc_in, sp_in;
    logic [7:0]  flags_in;
    logic [15:0] pc_out, sp_out;
    logic [7:0]  flags_out;
    logic        pc_load, flags_load, sp_load;
    logic        stall, ie;
    logic [3:0]  dbg_state;

    int_entry_if mem_if ();

    int_entry dut (
        .clk(clk), .reset(reset), .interrupt(interrupt), .intVect(intVect), .intAck(intAck),
        .instr_boundary(instr_boundary), .ei(ei), .di(di), .reti(reti),
        .pc_in(pc_in), .flags_in(flags_in), .sp_in(sp_in),
        .pc_out(pc_out), .pc_load(pc_load), .flags_out(flags_out), .flags_load(flags_load),
        .sp_out(sp_out), .sp_load(sp_load), .mem(mem_if), .stall(stall), .ie(ie),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- memory behind the stack bus ----------------
    logic [7:0] sim_mem [logic [15:0]];

    always @(posedge clk) begin
        if (mem_if.mem_w_en) sim_mem[mem_if.mem_addr] = mem_if.mem_dout;
        if (mem_if.mem_r_en && sim_mem.exists(mem_if.mem_addr))
            mem_if.mem_din <= sim_mem[mem_if.mem_addr];
        else
            mem_if.mem_din <= 8'h00;
    end

    // ---------------- model ----------------
    logic [OBS_W-1:0] exp_q[$];
    logic [7:0]  ref_mem [logic [15:0]];
    int          n_vec = 0;
    int          n_bad = 0;
    bit          started = 1'b0;
    logic        ie_m = 1'b0;
    logic        ie_after = 1'b0;
    int          busy = 0;
    logic [15:0] last_pc, last_sp;
    logic [7:0]  last_flags;

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic obs_t stall_rec();
        obs_t o;
        o       = '0;
        o.stall = 1'b1;
        o.ie    = ie_m;
        return o;
    endfunction

    task automatic push_entry(input logic [15:0] sp, input logic [15:0] pc,
                              input logic [7:0] f, input logic [15:0] vec);
        obs_t o;
        o = stall_rec(); o.int_ack = 1'b1; o.w = 1'b1; o.addr = sp - 16'd1; o.dout = pc[15:8];
        exp_q.push_back(o);
        o = stall_rec(); o.w = 1'b1; o.addr = sp - 16'd2; o.dout = pc[7:0];
        exp_q.push_back(o);
        o = stall_rec(); o.w = 1'b1; o.addr = sp - 16'd3; o.dout = f;
        exp_q.push_back(o);
        o = stall_rec(); o.pc_load = 1'b1; o.pc_out = vec; o.sp_load = 1'b1; o.sp_out = sp - 16'd3;
        exp_q.push_back(o);
    endtask

    task automatic push_return(input logic [15:0] sp);
        obs_t o;
        for (int k = 0; k < 3; k++) begin
            o = stall_rec(); o.r = 1'b1; o.addr = sp + 16'(k);
            exp_q.push_back(o);
        end
        exp_q.push_back(stall_rec());
        o = stall_rec();
        o.pc_load    = 1'b1; o.pc_out = {ref_rd(sp + 16'd2), ref_rd(sp + 16'd1)};
        o.flags_load = 1'b1; o.flags_out = ref_rd(sp);
        o.sp_load    = 1'b1; o.sp_out = sp + 16'd3;
        exp_q.push_back(o);
    endtask

    always @(posedge clk) begin : model_b
        logic acc;
        started = 1'b1;
        if (!reset) begin
            exp_q.delete();
            busy = 0;
            ie_m = 1'b0;
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) ie_m = ie_after;
        end else if (instr_boundary) begin
            acc = interrupt && ie_m && !reti;
            if (di)      ie_m = 1'b0;
            else if (ei) ie_m = 1'b1;
            if (reti) begin
                push_return(sp_in);
                busy = 5; ie_after = 1'b1;
            end else if (acc) begin
                push_entry(sp_in, pc_in, flags_in, intVect);
                busy = 4; ie_after = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : cmp_b
        obs_t e, a;
        if (started) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else begin e = '0; e.ie = ie_m; end
            if (e.w) ref_mem[e.addr] = e.dout;
            a = '{stall, intAck, mem_if.mem_w_en, mem_if.mem_r_en, mem_if.mem_addr, mem_if.mem_dout,
                  pc_load, pc_out, flags_load, flags_out, sp_load, sp_out, ie};
            n_vec++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL cycle_check t=%0t state=%0d dut=%h model=%h", $time, dbg_state, a, e);
            end
            if (a.pc_load) last_pc = a.pc_out;
            if (a.sp_load) last_sp = a.sp_out;
            if (a.flags_load) last_flags = a.flags_out;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_stall(input int exp_n, input string nm);
        int n = 0;
        int g = 0;
        @(negedge clk);
        while (!stall && g < 10) begin g++; @(negedge clk); end
        while (stall && n < 20) begin n++; @(negedge clk); end
        chk(nm, n, exp_n);
    endtask

    task automatic pulse_ei();
        ei = 1'b1; instr_boundary = 1'b1;
        tick();
        ei = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset = 1'b0; interrupt = 1'b0; intVect = 16'h0; instr_boundary = 1'b0;
        ei = 1'b0; di = 1'b0; reti = 1'b0; pc_in = 16'h0; flags_in = 8'h0; sp_in = 16'h0;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_stall", stall, 0);
        chk("reset_ie", ie, 0);
        chk("reset_pc_load", pc_load, 0);
        tick();
        reset = 1'b1;

        // masked interrupt, then ei enables acceptance one cycle later
        instr_boundary = 1'b1; interrupt = 1'b1; intVect = 16'h0400;
        pc_in = 16'h1234; flags_in = 8'hA5; sp_in = 16'h2000;
        repeat (3) tick();
        @(negedge clk);
        chk("masked_stall", stall, 0);
        chk("masked_ack", intAck, 0);
        tick();
        pulse_ei();
        @(negedge clk);
        chk("ei_same_cycle_no_accept", stall, 0);
        tick();
        intVect = 16'hFFFF; interrupt = 1'b0;
        count_stall(4, "entry_stall_cycles");
        chk("entry_mem_1fff", sim_mem.exists(16'h1FFF) ? sim_mem[16'h1FFF] : 8'hXX, 8'h12);
        chk("entry_mem_1ffe", sim_mem.exists(16'h1FFE) ? sim_mem[16'h1FFE] : 8'hXX, 8'h34);
        chk("entry_mem_1ffd", sim_mem.exists(16'h1FFD) ? sim_mem[16'h1FFD] : 8'hXX, 8'hA5);
        chk("entry_pc_out", last_pc, 16'h0400);
        chk("entry_sp_out", last_sp, 16'h1FFD);
        chk("entry_ie", ie, 0);

        // return
        tick();
        sp_in = 16'h1FFD; reti = 1'b1;
        tick();
        reti = 1'b0;
        count_stall(5, "return_stall_cycles");
        chk("ret_pc_out", last_pc, 16'h1234);
        chk("ret_flags_out", last_flags, 8'hA5);
        chk("ret_sp_out", last_sp, 16'h2000);
        chk("ret_ie", ie, 1);

        // reti and interrupt together: return first, entry afterwards
        tick();
        reti = 1'b1; interrupt = 1'b1; intVect = 16'h0800;
        tick();
        reti = 1'b0; sp_in = 16'h2000; pc_in = 16'h1234; flags_in = 8'hA5;
        count_stall(5, "simul_return_first");
        chk("simul_ret_pc", last_pc, 16'h1234);
        tick();
        interrupt = 1'b0;
        count_stall(4, "simul_entry_after");
        chk("simul_entry_pc", last_pc, 16'h0800);

        // stack pointer wrap
        tick();
        pulse_ei();
        sp_in = 16'h0001; pc_in = 16'hBEEF; flags_in = 8'h5A; intVect = 16'h0100; interrupt = 1'b1;
        tick();
        interrupt = 1'b0;
        count_stall(4, "wrap_entry_stall");
        chk("wrap_mem_0000", sim_mem.exists(16'h0000) ? sim_mem[16'h0000] : 8'hXX, 8'hBE);
        chk("wrap_mem_ffff", sim_mem.exists(16'hFFFF) ? sim_mem[16'hFFFF] : 8'hXX, 8'hEF);
        chk("wrap_mem_fffe", sim_mem.exists(16'hFFFE) ? sim_mem[16'hFFFE] : 8'hXX, 8'h5A);
        chk("wrap_sp_out", last_sp, 16'hFFFE);
        tick();
        sp_in = 16'hFFFE; reti = 1'b1;
        tick();
        reti = 1'b0;
        count_stall(5, "wrap_return_stall");
        chk("wrap_ret_sp", last_sp, 16'h0001);
        chk("wrap_ret_pc", last_pc, 16'hBEEF);
        chk("wrap_ret_flags", last_flags, 8'h5A);

        // reset in the middle of PUSH_L
        tick();
        sp_in = 16'h3000; pc_in = 16'h1111; flags_in = 8'h11; intVect = 16'h0900; interrupt = 1'b1;
        tick();
        interrupt = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("abort_stall", stall, 0);
        chk("abort_mem_w_en", mem_if.mem_w_en, 0);
        chk("abort_ie", ie, 0);
        chk("abort_pc_load", pc_load, 0);
        chk("abort_no_flags_push", sim_mem.exists(16'h2FFD), 0);
        chk("abort_pch_pushed", sim_mem.exists(16'h2FFF), 1);
        repeat (3) tick();

        // enable controls
        ei = 1'b1; di = 1'b1;
        tick();
        ei = 1'b0; di = 1'b0;
        @(negedge clk);
        chk("ei_di_both_ie", ie, 0);
        tick();
        pulse_ei();
        @(negedge clk);
        chk("ei_sets_ie", ie, 1);
        tick();
        instr_boundary = 1'b0; di = 1'b1;
        tick();
        di = 1'b0;
        @(negedge clk);
        chk("di_off_boundary_ignored", ie, 1);
        tick();
        instr_boundary = 1'b1; di = 1'b1;
        tick();
        di = 1'b0;
        @(negedge clk);
        chk("di_clears_ie", ie, 0);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
